// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on the fetch PC; training and statistics update on the clock.
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        predicted_taken,
    output logic [31:0] pred_next_pc,
    input  logic        ex_update,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_mispredict,
    input  logic        btb_flush,
    input  logic        stat_clr,
    output logic [31:0] stat_ctrl_count,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned TAG_W = 30 - INDEX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [31:0] ctrl_cnt_q;
    logic [31:0] mispred_cnt_q;

    logic [INDEX_W-1:0] rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_hit;

    logic [INDEX_W-1:0] wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    logic               wr_hit;

    // Lookup path: reads only, so an unknown fetch PC cannot reach any state.
    always_comb begin
        rd_idx          = if_pc[INDEX_W+1:2];
        rd_tag          = if_pc[31:INDEX_W+2];
        rd_hit          = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        predicted_taken = rd_hit && ctr_q[rd_idx][1];
        pred_next_pc    = predicted_taken ? target_q[rd_idx] : (if_pc + 32'd4);
    end

    always_comb begin
        wr_idx = ex_pc[INDEX_W+1:2];
        wr_tag = ex_pc[31:INDEX_W+2];
        wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (btb_flush) begin
            // Flush drops any same-cycle training; only valid bits are cleared.
            valid_q <= '0;
        end else if (ex_update) begin
            if (wr_hit) begin
                if (ex_taken) begin
                    target_q[wr_idx] <= ex_target;
                    if (ctr_q[wr_idx] != 2'b11) begin
                        ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
                    end
                end else if (ctr_q[wr_idx] != 2'b00) begin
                    ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= ex_target;
                ctr_q[wr_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else if (stat_clr) begin
            ctrl_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else if (ex_update) begin
            if (ctrl_cnt_q != '1) begin
                ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
            end
            if (ex_mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign stat_ctrl_count  = ctrl_cnt_q;
    assign stat_mispredicts = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_branch_target_buffer;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned INDEX_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        predicted_taken;
    logic [31:0] pred_next_pc;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_mispredict;
    logic        btb_flush;
    logic        stat_clr;
    logic [31:0] stat_ctrl_count;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(
        .ENTRIES(ENTRIES),
        .INDEX_W(INDEX_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .predicted_taken (predicted_taken),
        .pred_next_pc    (pred_next_pc),
        .ex_update       (ex_update),
        .ex_pc           (ex_pc),
        .ex_target       (ex_target),
        .ex_taken        (ex_taken),
        .ex_mispredict   (ex_mispredict),
        .btb_flush       (btb_flush),
        .stat_clr        (stat_clr),
        .stat_ctrl_count (stat_ctrl_count),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Behavioural model: one record per index, counter kept as a plain integer 0..3.
    bit              m_valid  [ENTRIES];
    int unsigned     m_tag    [ENTRIES];
    logic [31:0]     m_target [ENTRIES];
    int              m_ctr    [ENTRIES];
    longint unsigned m_ctrl;
    longint unsigned m_mis;
    localparam longint unsigned STAT_MAX = 64'hFFFF_FFFF;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (INDEX_W + 2);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_ctrl = 0;
        m_mis  = 0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic tk,
                                          output logic [31:0] np);
        int unsigned i;
        i  = idx_of(pc);
        tk = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        np = tk ? m_target[i] : pc + 32'd4;
    endfunction

    // Applies the currently driven inputs as if a rising edge just happened.
    function automatic void model_update();
        int unsigned i;
        bit hit;
        i   = idx_of(ex_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
        if (btb_flush) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (ex_update) begin
            if (hit && ex_taken) begin
                m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = ex_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end else if (ex_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(ex_pc);
                m_target[i] = ex_target;
                m_ctr[i]    = 2;
            end
        end
        if (stat_clr) begin
            m_ctrl = 0;
            m_mis  = 0;
        end else if (ex_update) begin
            if (m_ctrl < STAT_MAX) m_ctrl++;
            if (ex_mispredict && m_mis < STAT_MAX) m_mis++;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic upd, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic mis, input logic fl,
                         input logic clr, input logic [31:0] ipc);
        ex_update     = upd;
        ex_pc         = pc;
        ex_taken      = tk;
        ex_target     = tgt;
        ex_mispredict = mis;
        btb_flush     = fl;
        stat_clr      = clr;
        if_pc         = ipc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, if_pc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h100);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_model(input string name);
        logic        tk;
        logic [31:0] np;
        model_predict(if_pc, tk, np);
        check({name, ".taken"}, {63'b0, predicted_taken}, {63'b0, tk});
        check({name, ".next_pc"}, {32'b0, pred_next_pc}, {32'b0, np});
        check({name, ".ctrl"}, {32'b0, stat_ctrl_count}, m_ctrl);
        check({name, ".mis"}, {32'b0, stat_mispredicts}, m_mis);
    endtask

    typedef struct {
        logic        upd;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] ifpc;
        logic        exp_tk;
        logic [31:0] exp_np;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic upd, input logic [31:0] pc, input logic tk,
                                input logic [31:0] tgt, input logic [31:0] ipc,
                                input logic etk, input logic [31:0] enp);
        vec_t v;
        v.upd = upd; v.pc = pc; v.tk = tk; v.tgt = tgt;
        v.ifpc = ipc; v.exp_tk = etk; v.exp_np = enp;
        return v;
    endfunction

    initial begin
        // Expected values are those seen before the row's own clock edge.
        vecs[0]  = mk(0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104);
        vecs[1]  = mk(1, 32'h100, 1, 32'h200, 32'h100, 0, 32'h104);
        vecs[2]  = mk(0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h200);
        vecs[3]  = mk(0, 32'h0,   0, 32'h0,   32'h140, 0, 32'h144);
        vecs[4]  = mk(1, 32'h100, 0, 32'h0,   32'h100, 1, 32'h200);
        vecs[5]  = mk(1, 32'h100, 0, 32'h0,   32'h100, 0, 32'h104);
        vecs[6]  = mk(1, 32'h100, 0, 32'h0,   32'h100, 0, 32'h104);
        vecs[7]  = mk(1, 32'h100, 1, 32'h200, 32'h100, 0, 32'h104);
        vecs[8]  = mk(1, 32'h100, 1, 32'h220, 32'h100, 0, 32'h104);
        vecs[9]  = mk(0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h220);
        vecs[10] = mk(1, 32'h300, 1, 32'h440, 32'h300, 0, 32'h304);
        vecs[11] = mk(0, 32'h0,   0, 32'h0,   32'h300, 1, 32'h440);
        vecs[12] = mk(0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104);
        vecs[13] = mk(1, 32'h104, 1, 32'h500, 32'h104, 0, 32'h108);
        vecs[14] = mk(1, 32'h104, 1, 32'h504, 32'h104, 1, 32'h500);
        vecs[15] = mk(1, 32'h104, 1, 32'h508, 32'h104, 1, 32'h504);
        vecs[16] = mk(1, 32'h104, 0, 32'h0,   32'h104, 1, 32'h508);
        vecs[17] = mk(0, 32'h0,   0, 32'h0,   32'h104, 1, 32'h508);
        vecs[18] = mk(1, 32'h208, 0, 32'h999, 32'h208, 0, 32'h20C);
        vecs[19] = mk(0, 32'h0,   0, 32'h0,   32'h208, 0, 32'h20C);
        vecs[20] = mk(0, 32'h0,   0, 32'h0,   32'hFFFF_FFFC, 0, 32'h0);

        do_reset();
        check("reset.taken", {63'b0, predicted_taken}, 64'd0);
        check("reset.next_pc", {32'b0, pred_next_pc}, 64'h104);
        check("reset.ctrl", {32'b0, stat_ctrl_count}, 64'd0);
        check("reset.mis", {32'b0, stat_mispredicts}, 64'd0);

        for (int n = 0; n < NVEC; n++) begin
            drive(vecs[n].upd, vecs[n].pc, vecs[n].tk, vecs[n].tgt, 1'b0, 1'b0, 1'b0,
                  vecs[n].ifpc);
            check($sformatf("vec%0d.taken", n), {63'b0, predicted_taken}, {63'b0, vecs[n].exp_tk});
            check($sformatf("vec%0d.next_pc", n), {32'b0, pred_next_pc}, {32'b0, vecs[n].exp_np});
            tick();
        end

        // Flush together with a taken update: update dropped, every entry misses.
        drive(1'b1, 32'h10C, 1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 32'h300);
        tick();
        idle();
        for (int n = 0; n < 3; n++) begin
            logic [31:0] pcs [3];
            pcs[0] = 32'h300; pcs[1] = 32'h104; pcs[2] = 32'h10C;
            if_pc = pcs[n];
            #1;
            check($sformatf("flush.taken%0d", n), {63'b0, predicted_taken}, 64'd0);
            check($sformatf("flush.next%0d", n), {32'b0, pred_next_pc}, {32'b0, pcs[n] + 32'd4});
        end

        // Statistics: 5 updates (2 mispredicted) plus one lone mispredict.
        do_reset();
        for (int n = 0; n < 6; n++) begin
            logic upd;
            logic mis;
            upd = (n != 3);
            mis = (n == 1) || (n == 3) || (n == 4);
            drive(upd, 32'h400 + 32'(n * 4), 1'b0, '0, mis, 1'b0, 1'b0, 32'h0);
            tick();
        end
        idle();
        check("stat.ctrl5", {32'b0, stat_ctrl_count}, 64'd5);
        check("stat.mis2", {32'b0, stat_mispredicts}, 64'd2);
        drive(1'b1, 32'h400, 1'b1, 32'h800, 1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        idle();
        check("stat.clr_ctrl", {32'b0, stat_ctrl_count}, 64'd0);
        check("stat.clr_mis", {32'b0, stat_mispredicts}, 64'd0);

        // Saturation of the control-instruction counter.
        force dut.ctrl_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.ctrl_cnt_q;
        m_ctrl = 64'hFFFF_FFFE;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 32'h500, 1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 32'h500);
            tick();
        end
        idle();
        check("stat.sat", {32'b0, stat_ctrl_count}, 64'hFFFF_FFFF);
        check("stat.sat_model", {32'b0, stat_ctrl_count}, m_ctrl);

        // Asynchronous reset between edges with a trained entry being looked up.
        if_pc = 32'h500;
        #1;
        check("prereset.taken", {63'b0, predicted_taken}, 64'd1);
        drive(1'b1, 32'h500, 1'b1, 32'hA00, 1'b1, 1'b0, 1'b0, 32'h500);
        #1;
        rst_n = 1'b0;
        #1;
        check("async.taken", {63'b0, predicted_taken}, 64'd0);
        check("async.next_pc", {32'b0, pred_next_pc}, 64'h504);
        check("async.ctrl", {32'b0, stat_ctrl_count}, 64'd0);
        check("async.mis", {32'b0, stat_mispredicts}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle();
        check("postreset.taken", {63'b0, predicted_taken}, 64'd0);
        check("postreset.ctrl", {32'b0, stat_ctrl_count}, 64'd0);

        // Randomized traffic over a small PC pool so entries collide and retrain.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] upc;
            logic [31:0] lpc;
            upc = (32'($urandom_range(0, 3)) << (INDEX_W + 2)) |
                  (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                lpc = $urandom;
            end else begin
                lpc = (32'($urandom_range(0, 3)) << (INDEX_W + 2)) |
                      (32'($urandom_range(0, ENTRIES - 1)) << 2) |
                      32'($urandom_range(0, 3));
            end
            drive(1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 2) != 0), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 39) == 0), lpc);
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
